// File: rtl/ps2_drive_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ps2_drive_ctrl
// Purpose  : PS/2 scan-byte decoder driving a gear/speed model from W/S/arrows.
// Revision : 1.0
// ============================================================================
module ps2_drive_ctrl #(
  parameter int unsigned TICK_DIV = 12500000,
  parameter int unsigned TIMEOUT  = 100000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_data_i,
  output logic       evt_valid_o,
  output logic [7:0] evt_code_o,
  output logic       evt_ext_o,
  output logic       evt_break_o,
  output logic       seq_err_o,
  output logic [3:0] held_o,
  output logic [6:0] speed_o,
  output logic [1:0] gear_o
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  localparam int unsigned TK_W = $clog2(TICK_DIV + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [TO_W-1:0]   to_cnt_q;
  logic [TK_W-1:0]   tick_cnt_q;
  logic              evt_valid_q, evt_ext_q, evt_break_q, seq_err_q;
  logic [7:0]        evt_code_q;
  logic [3:0]        held_q, held_d;
  logic [6:0]        speed_q, speed_d;
  logic [1:0]        gear_q, gear_d;

  logic              fire, fire_ext, fire_brk, to_hit, tick, discard;
  logic [3:0]        key_hit;
  logic [6:0]        cap;

  always_comb begin
    fire     = 1'b0;
    fire_ext = 1'b0;
    fire_brk = 1'b0;
    state_d  = state_q;
    discard  = (byte_data_i == 8'h00) || (byte_data_i == 8'hAA) ||
               (byte_data_i == 8'hEE) || (byte_data_i == 8'hFA) ||
               (byte_data_i == 8'hFE) || (byte_data_i == 8'hFF);
    to_hit   = !byte_valid_i && (state_q != S_IDLE) &&
               (to_cnt_q == TO_W'(TIMEOUT - 1));
    if (byte_valid_i) begin
      case (state_q)
        S_IDLE: begin
          if (byte_data_i == 8'hE0)      state_d = S_EXT;
          else if (byte_data_i == 8'hF0) state_d = S_BRK;
          else if (!discard)             fire = 1'b1;
        end
        S_EXT: begin
          if (byte_data_i == 8'hF0) state_d = S_EXT_BRK;
          else if (byte_data_i != 8'hE0) begin
            fire = 1'b1; fire_ext = 1'b1; state_d = S_IDLE;
          end
        end
        S_BRK: begin
          if (byte_data_i == 8'hE0) state_d = S_EXT_BRK;
          else if (byte_data_i != 8'hF0) begin
            fire = 1'b1; fire_brk = 1'b1; state_d = S_IDLE;
          end
        end
        default: begin
          if (byte_data_i != 8'hE0 && byte_data_i != 8'hF0) begin
            fire = 1'b1; fire_ext = 1'b1; fire_brk = 1'b1; state_d = S_IDLE;
          end
        end
      endcase
    end else if (to_hit) begin
      state_d = S_IDLE;
    end
  end

  // Bit order of key_hit matches held: {dn, up, S, W}.
  always_comb begin
    key_hit[0] = fire && !fire_ext && (byte_data_i == 8'h1D);
    key_hit[1] = fire && !fire_ext && (byte_data_i == 8'h1B);
    key_hit[2] = fire &&  fire_ext && (byte_data_i == 8'h75);
    key_hit[3] = fire &&  fire_ext && (byte_data_i == 8'h72);
    held_d = fire_brk ? (held_q & ~key_hit) : (held_q | key_hit);
    gear_d = gear_q;
    if (!fire_brk && key_hit[2] && !held_q[2] && gear_q != 2'd3)
      gear_d = gear_q + 2'd1;
    else if (!fire_brk && key_hit[3] && !held_q[3] && gear_q != 2'd0)
      gear_d = gear_q - 2'd1;
  end

  always_comb begin
    tick = (tick_cnt_q == '0);
    case (gear_q)
      2'd0:    cap = 7'd25;
      2'd1:    cap = 7'd50;
      2'd2:    cap = 7'd75;
      default: cap = 7'd99;
    endcase
    speed_d = speed_q;
    if (speed_q > cap)      speed_d = speed_q - 7'd1;
    else if (held_q[1])     speed_d = (speed_q < 7'd3) ? 7'd0 : speed_q - 7'd3;
    else if (held_q[0])     speed_d = (speed_q >= cap) ? cap : speed_q + 7'd1;
    else if (speed_q != '0) speed_d = speed_q - 7'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      to_cnt_q    <= '0;
      tick_cnt_q  <= TK_W'(TICK_DIV - 1);
      evt_valid_q <= 1'b0;
      evt_code_q  <= 8'h00;
      evt_ext_q   <= 1'b0;
      evt_break_q <= 1'b0;
      seq_err_q   <= 1'b0;
      held_q      <= 4'b0000;
      speed_q     <= 7'd0;
      gear_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= (byte_valid_i || to_hit || state_q == S_IDLE) ? '0 : to_cnt_q + 1'b1;
      tick_cnt_q  <= tick ? TK_W'(TICK_DIV - 1) : tick_cnt_q - 1'b1;
      evt_valid_q <= fire;
      seq_err_q   <= to_hit;
      if (fire) begin
        evt_code_q  <= byte_data_i;
        evt_ext_q   <= fire_ext;
        evt_break_q <= fire_brk;
        held_q      <= held_d;
        gear_q      <= gear_d;
      end
      // Tick reads the pre-event held/gear, so same-cycle events never leak in.
      if (tick) speed_q <= speed_d;
    end
  end

  assign evt_valid_o = evt_valid_q;
  assign evt_code_o  = evt_code_q;
  assign evt_ext_o   = evt_ext_q;
  assign evt_break_o = evt_break_q;
  assign seq_err_o   = seq_err_q;
  assign held_o      = held_q;
  assign speed_o     = speed_q;
  assign gear_o      = gear_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_drive_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_drive_ctrl
// Purpose  : Scoreboard bench for ps2_drive_ctrl (TICK_DIV=8, TIMEOUT=20).
// Revision : 1.0
// ============================================================================
module tb_ps2_drive_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       byte_valid_i = 1'b0;
  logic [7:0] byte_data_i = 8'h00;
  logic       evt_valid_o, evt_ext_o, evt_break_o, seq_err_o;
  logic [7:0] evt_code_o;
  logic [3:0] held_o;
  logic [6:0] speed_o;
  logic [1:0] gear_o;

  ps2_drive_ctrl #(.TICK_DIV(8), .TIMEOUT(20)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i),
    .evt_valid_o(evt_valid_o), .evt_code_o(evt_code_o),
    .evt_ext_o(evt_ext_o), .evt_break_o(evt_break_o),
    .seq_err_o(seq_err_o), .held_o(held_o),
    .speed_o(speed_o), .gear_o(gear_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [3:0] held;
    logic [1:0] gear;
  } evt_t;

  evt_t       evq[$];
  logic [6:0] spq[$];
  int         seq_exp = 0;
  int         checks = 0;
  int         errors = 0;
  logic [6:0] last_speed = 7'd0;
  evt_t       cur;
  logic [6:0] sp_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_evt(input logic [7:0] code, input logic ext, input logic brk,
                         input logic [3:0] held, input logic [1:0] gear);
    evq.push_back('{code: code, ext: ext, brk: brk, held: held, gear: gear});
  endtask

  task automatic exp_speeds(input int from, input int to);
    if (from <= to) for (int v = from; v <= to; v++) spq.push_back(7'(v));
    else            for (int v = from; v >= to; v--) spq.push_back(7'(v));
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk_i);
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    @(negedge clk_i);
    byte_valid_i = 1'b0;
  endtask

  task automatic wait_speed(input logic [6:0] target);
    int n = 0;
    while (speed_o !== target && n < 600) begin
      @(negedge clk_i);
      n++;
    end
    if (speed_o !== target) begin
      checks++;
      errors++;
      $display("FAIL wait_speed: got %0d, expected %0d within budget", speed_o, target);
    end
  endtask

  // Monitor: every DUT-presented output is matched against the scoreboard.
  always @(negedge clk_i) begin
    if (evt_valid_o) begin
      if (evq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_evt: got code %0h, expected no event", evt_code_o);
      end else begin
        cur = evq.pop_front();
        chk("evt_code", 32'(evt_code_o), 32'(cur.code));
        chk("evt_ext", 32'(evt_ext_o), 32'(cur.ext));
        chk("evt_break", 32'(evt_break_o), 32'(cur.brk));
        chk("held", 32'(held_o), 32'(cur.held));
        chk("gear", 32'(gear_o), 32'(cur.gear));
      end
    end
    if (seq_err_o) begin
      checks++;
      if (seq_exp > 0) seq_exp--;
      else begin
        errors++;
        $display("FAIL unexpected_seq_err: got 1, expected 0");
      end
    end
    if (speed_o !== last_speed) begin
      if (spq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_speed: got %0d, expected %0d", speed_o, last_speed);
      end else begin
        sp_exp = spq.pop_front();
        chk("speed", 32'(speed_o), 32'(sp_exp));
      end
      last_speed = speed_o;
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_evt_valid"}, 32'(evt_valid_o), 32'd0);
    chk({tag, "_evt_code"}, 32'(evt_code_o), 32'h00);
    chk({tag, "_evt_ext"}, 32'(evt_ext_o), 32'd0);
    chk({tag, "_evt_break"}, 32'(evt_break_o), 32'd0);
    chk({tag, "_seq_err"}, 32'(seq_err_o), 32'd0);
    chk({tag, "_held"}, 32'(held_o), 32'd0);
    chk({tag, "_speed"}, 32'(speed_o), 32'd0);
    chk({tag, "_gear"}, 32'(gear_o), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    chk_reset_state("rst");
    rst_ni = 1'b1;

    // Discardable bytes in IDLE produce nothing.
    send(8'h00);
    send(8'hFA);

    // W make, then up-arrow release; speed climbs to the gear-0 cap.
    exp_speeds(1, 25);
    exp_evt(8'h1D, 1'b0, 1'b0, 4'b0001, 2'd0);
    send(8'h1D);
    exp_evt(8'h75, 1'b1, 1'b1, 4'b0001, 2'd0);
    send(8'hE0); send(8'hF0); send(8'h75);
    repeat (320) @(negedge clk_i);
    chk("speed_cap0", 32'(speed_o), 32'd25);

    // Up arrow to gear 1; typematic repeat must not shift again.
    exp_speeds(26, 50);
    exp_evt(8'h75, 1'b1, 1'b0, 4'b0101, 2'd1);
    send(8'hE0); send(8'h75);
    exp_evt(8'h75, 1'b1, 1'b0, 4'b0101, 2'd1);
    send(8'hE0); send(8'h75);
    repeat (240) @(negedge clk_i);
    chk("speed_cap1", 32'(speed_o), 32'd50);
    exp_evt(8'h75, 1'b1, 1'b1, 4'b0001, 2'd1);
    send(8'hE0); send(8'hF0); send(8'h75);

    // Down arrow to gear 0; speed bleeds back to 25 despite W.
    exp_speeds(49, 25);
    exp_evt(8'h72, 1'b1, 1'b0, 4'b1001, 2'd0);
    send(8'hE0); send(8'h72);
    exp_evt(8'h72, 1'b1, 1'b0, 4'b1001, 2'd0);
    send(8'hE0); send(8'h72);
    repeat (240) @(negedge clk_i);
    exp_evt(8'h72, 1'b1, 1'b1, 4'b0001, 2'd0);
    send(8'hE0); send(8'hF0); send(8'h72);

    // Release W, coast to 10, then W+S held: S wins.
    exp_speeds(24, 10);
    spq.push_back(7'd7); spq.push_back(7'd4); spq.push_back(7'd1); spq.push_back(7'd0);
    exp_evt(8'h1D, 1'b0, 1'b1, 4'b0000, 2'd0);
    send(8'hF0); send(8'h1D);
    wait_speed(7'd10);
    exp_evt(8'h1D, 1'b0, 1'b0, 4'b0001, 2'd0);
    send(8'h1D);
    exp_evt(8'h1B, 1'b0, 1'b0, 4'b0011, 2'd0);
    send(8'h1B);
    repeat (60) @(negedge clk_i);
    chk("speed_ws", 32'(speed_o), 32'd0);

    // Lone E0 times out; next byte decodes from IDLE.
    seq_exp = 1;
    send(8'hE0);
    repeat (30) @(negedge clk_i);
    chk("seq_err_seen", 32'(seq_exp), 32'd0);
    exp_evt(8'h1B, 1'b0, 1'b0, 4'b0011, 2'd0);
    send(8'h1B);

    // Build up to gear 2 / speed 30, then reset mid-sequence.
    exp_speeds(1, 30);
    spq.push_back(7'd0);
    exp_evt(8'h1B, 1'b0, 1'b1, 4'b0001, 2'd0);
    send(8'hF0); send(8'h1B);
    exp_evt(8'h75, 1'b1, 1'b0, 4'b0101, 2'd1);
    send(8'hE0); send(8'h75);
    exp_evt(8'h75, 1'b1, 1'b1, 4'b0001, 2'd1);
    send(8'hE0); send(8'hF0); send(8'h75);
    exp_evt(8'h75, 1'b1, 1'b0, 4'b0101, 2'd2);
    send(8'hE0); send(8'h75);
    wait_speed(7'd30);
    chk("gear_pre_rst", 32'(gear_o), 32'd2);
    send(8'hE0); send(8'hF0);
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    chk_reset_state("midrst");
    rst_ni = 1'b1;
    exp_evt(8'h75, 1'b0, 1'b0, 4'b0000, 2'd0);
    send(8'h75);
    repeat (20) @(negedge clk_i);

    chk("evq_drained", 32'(evq.size()), 32'd0);
    chk("spq_drained", 32'(spq.size()), 32'd0);
    chk("seq_drained", 32'(seq_exp), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
